// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, aluop_d codes, mux select codes and state encoding shared by the multicycle controller
package riscv_ctrl_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [2:0] F3_BNE    = 3'b001;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_IMM = 4'b0010;
    localparam logic [3:0] ALU_R   = 4'b0110;
    localparam logic [3:0] ALU_BNE = 4'b1100;
    localparam logic [3:0] ALU_JAL = 4'b1101;
    localparam logic [3:0] ALU_LUI = 4'b0111;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R,
        EXEC_I, ALUWB, BRANCH, JAL, LUI, TRAP
    } state_t;
endpackage

// File: rtl/main_aluop_enc.sv
// main_aluop_enc: maps controller state to the aluop_d code consumed by ALU_Control
module main_aluop_enc
    import riscv_ctrl_pkg::*;
(
    input  state_t      state,
    output logic [3:0]  aluop_d
);
    always_comb begin
        aluop_d = state == EXEC_R ? ALU_R   :
                  state == EXEC_I ? ALU_IMM :
                  state == BRANCH ? ALU_BNE :
                  state == JAL    ? ALU_JAL :
                  state == LUI    ? ALU_LUI : ALU_ADD;
    end
endmodule

// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle RISC-V main controller with retired-instruction count and illegal-opcode trap
module main_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [3:0]       aluop_d,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       resultsrc,
    output logic             adr_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);
    state_t state, next_state;
    logic [3:0] enc_aluop;
    logic retire;

    main_aluop_enc u_enc (.state(state), .aluop_d(enc_aluop));

    assign aluop_d = reset ? ALU_ADD : enc_aluop;
    assign retire  = next_state == FETCH &&
                     (state == MEMWB || state == MEMWRITE || state == ALUWB || state == BRANCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            instret <= '0;
        end else begin
            state <= next_state;
            if (retire) instret <= instret + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        alusrca    = SRCA_PC;
        alusrcb    = SRCB_RS2;
        resultsrc  = RES_ALUOUT;
        adr_src    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                alusrcb    = SRCB_FOUR;
                resultsrc  = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_IMM;
                next_state = (opcode == OP_LOAD || opcode == OP_STORE) ? MEMADR :
                             opcode == OP_R   ? EXEC_R :
                             opcode == OP_I   ? EXEC_I :
                             (opcode == OP_BRANCH && funct3 == F3_BNE) ? BRANCH :
                             opcode == OP_JAL ? JAL :
                             opcode == OP_LUI ? LUI : TRAP;
            end
            MEMADR: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_IMM;
                next_state = opcode == OP_STORE ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req    = 1'b1;
                adr_src    = 1'b1;
                next_state = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                resultsrc  = RES_MEM;
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                adr_src    = 1'b1;
                next_state = mem_ready ? FETCH : MEMWRITE;
            end
            EXEC_R: begin
                alusrca    = SRCA_RS1;
                next_state = ALUWB;
            end
            EXEC_I: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_IMM;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alusrca    = SRCA_RS1;
                pc_write   = ~zero;
                next_state = FETCH;
            end
            JAL: begin
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_FOUR;
                pc_write   = 1'b1;
                next_state = ALUWB;
            end
            LUI: begin
                alusrcb    = SRCB_IMM;
                next_state = ALUWB;
            end
            default: begin
                illegal    = 1'b1;
                next_state = TRAP;
            end
        endcase
        // Reset abandons any in-flight access in the same cycle; illegal stays visible until the edge.
        if (reset) begin
            {alusrca, alusrcb, resultsrc} = '0;
            {adr_src, mem_req, mem_we, ir_write, pc_write, reg_write} = '0;
        end
    end
endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm: table-driven per-cycle check of controller outputs and instret
module tb_main_control_fsm;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [3:0]  aluop_d;
    logic [1:0]  alusrca, alusrcb, resultsrc;
    logic        adr_src, mem_req, mem_we, ir_write, pc_write, reg_write, illegal;
    logic [31:0] instret;
    logic [16:0] act;
    int checks = 0;
    int fails = 0;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        z;
        logic        rdy;
        logic [16:0] ctrl;
        logic [31:0] cnt;
    } vec_t;
    vec_t vq[$];

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011, JA = 7'b1101111, LU = 7'b0110111, SY = 7'b1110011;

    main_control_fsm #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .aluop_d(aluop_d), .alusrca(alusrca), .alusrcb(alusrcb),
        .resultsrc(resultsrc), .adr_src(adr_src), .mem_req(mem_req), .mem_we(mem_we),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    assign act = {aluop_d, alusrca, alusrcb, resultsrc, adr_src, mem_req, mem_we,
                  ir_write, pc_write, reg_write, illegal};

    function automatic logic [16:0] ctl(input logic [3:0] al, input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] r, input logic adr, input logic req,
                                        input logic we, input logic ir, input logic pc,
                                        input logic rw, input logic ill);
        return {al, a, b, r, adr, req, we, ir, pc, rw, ill};
    endfunction

    task automatic step(input logic r, input logic [6:0] op, input logic [2:0] f3, input logic z,
                        input logic rdy, input logic [16:0] ec, input logic [31:0] en, input int id);
        reset = r; opcode = op; funct3 = f3; zero = z; mem_ready = rdy;
        #3;
        checks++;
        if (act !== ec) begin
            fails++;
            $display("FAIL ctrl step %0d: got %h expected %h", id, act, ec);
        end
        checks++;
        if (instret !== en) begin
            fails++;
            $display("FAIL instret step %0d: got %0d expected %0d", id, instret, en);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [16:0] c_rst, c_f0, c_f1, c_dec, c_ma, c_mr, c_mwb, c_mw, c_er, c_ei;
        logic [16:0] c_awb, c_br1, c_br0, c_jal, c_lui, c_tr, c_trr;
        c_rst = '0;
        c_f0  = ctl(4'h0, 2'd0, 2'd2, 2'd2, 0, 1, 0, 0, 0, 0, 0);
        c_f1  = ctl(4'h0, 2'd0, 2'd2, 2'd2, 0, 1, 0, 1, 1, 0, 0);
        c_dec = ctl(4'h0, 2'd1, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        c_ma  = ctl(4'h0, 2'd2, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        c_mr  = ctl(4'h0, 2'd0, 2'd0, 2'd0, 1, 1, 0, 0, 0, 0, 0);
        c_mwb = ctl(4'h0, 2'd0, 2'd0, 2'd1, 0, 0, 0, 0, 0, 1, 0);
        c_mw  = ctl(4'h0, 2'd0, 2'd0, 2'd0, 1, 1, 1, 0, 0, 0, 0);
        c_er  = ctl(4'h6, 2'd2, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        c_ei  = ctl(4'h2, 2'd2, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        c_awb = ctl(4'h0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0);
        c_br1 = ctl(4'hC, 2'd2, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0);
        c_br0 = ctl(4'hC, 2'd2, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        c_jal = ctl(4'hD, 2'd1, 2'd2, 2'd0, 0, 0, 0, 0, 1, 0, 0);
        c_lui = ctl(4'h7, 2'd0, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        c_tr  = ctl(4'h0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1);
        c_trr = c_tr;
        // lw with 2 FETCH waits and 1 MEMREAD wait
        vq.push_back('{1, LW, 0, 0, 0, c_rst, 0});
        vq.push_back('{1, LW, 0, 0, 1, c_rst, 0});
        vq.push_back('{0, LW, 0, 0, 0, c_f0, 0});
        vq.push_back('{0, LW, 0, 0, 0, c_f0, 0});
        vq.push_back('{0, LW, 0, 0, 1, c_f1, 0});
        vq.push_back('{0, LW, 0, 0, 1, c_dec, 0});
        vq.push_back('{0, LW, 0, 0, 1, c_ma, 0});
        vq.push_back('{0, LW, 0, 0, 0, c_mr, 0});
        vq.push_back('{0, LW, 0, 0, 1, c_mr, 0});
        vq.push_back('{0, LW, 0, 0, 1, c_mwb, 0});
        // R-type
        vq.push_back('{0, RT, 0, 0, 1, c_f1, 1});
        vq.push_back('{0, RT, 0, 0, 0, c_dec, 1});
        vq.push_back('{0, RT, 0, 0, 1, c_er, 1});
        vq.push_back('{0, RT, 0, 0, 1, c_awb, 1});
        // bne taken then not taken
        vq.push_back('{0, BR, 1, 0, 1, c_f1, 2});
        vq.push_back('{0, BR, 1, 0, 0, c_dec, 2});
        vq.push_back('{0, BR, 1, 0, 1, c_br1, 2});
        vq.push_back('{0, BR, 1, 1, 1, c_f1, 3});
        vq.push_back('{0, BR, 1, 1, 0, c_dec, 3});
        vq.push_back('{0, BR, 1, 1, 0, c_br0, 3});
        // jal
        vq.push_back('{0, JA, 0, 0, 1, c_f1, 4});
        vq.push_back('{0, JA, 0, 0, 0, c_dec, 4});
        vq.push_back('{0, JA, 0, 0, 1, c_jal, 4});
        vq.push_back('{0, JA, 0, 0, 0, c_awb, 4});
        // lui
        vq.push_back('{0, LU, 0, 0, 1, c_f1, 5});
        vq.push_back('{0, LU, 0, 0, 0, c_dec, 5});
        vq.push_back('{0, LU, 0, 0, 0, c_lui, 5});
        vq.push_back('{0, LU, 0, 0, 0, c_awb, 5});
        // I-type
        vq.push_back('{0, IT, 0, 0, 1, c_f1, 6});
        vq.push_back('{0, IT, 0, 0, 0, c_dec, 6});
        vq.push_back('{0, IT, 0, 0, 0, c_ei, 6});
        vq.push_back('{0, IT, 0, 0, 0, c_awb, 6});
        // zero-wait store
        vq.push_back('{0, SW, 0, 0, 1, c_f1, 7});
        vq.push_back('{0, SW, 0, 0, 0, c_dec, 7});
        vq.push_back('{0, SW, 0, 0, 0, c_ma, 7});
        vq.push_back('{0, SW, 0, 0, 1, c_mw, 7});
        // branch with funct3 other than bne traps
        vq.push_back('{0, BR, 0, 0, 1, c_f1, 8});
        vq.push_back('{0, BR, 0, 0, 0, c_dec, 8});
        vq.push_back('{0, BR, 0, 0, 1, c_tr, 8});
        vq.push_back('{0, BR, 0, 1, 1, c_tr, 8});

        @(posedge clk);
        #1;
        foreach (vq[i]) step(vq[i].rst, vq[i].op, vq[i].f3, vq[i].z, vq[i].rdy, vq[i].ctrl, vq[i].cnt, i);

        // reset out of TRAP, then SYSTEM opcode traps and stays trapped
        step(1, SY, 0, 0, 1, c_trr, 8, 100);
        step(0, SY, 0, 0, 1, c_f1, 0, 101);
        step(0, SY, 0, 0, 1, c_dec, 0, 102);
        for (int i = 0; i < 20; i++) begin
            logic [4:0] iv;
            iv = 5'(i);
            step(0, SY, 3'(i), iv[0], iv[1], c_tr, 0, 110 + i);
        end
        step(1, SY, 0, 0, 0, c_trr, 0, 130);
        step(0, LW, 0, 0, 0, c_f0, 0, 131);

        // reset mid-MEMWRITE abandons the store
        step(0, SW, 0, 0, 1, c_f1, 0, 140);
        step(0, SW, 0, 0, 0, c_dec, 0, 141);
        step(0, SW, 0, 0, 0, c_ma, 0, 142);
        step(0, SW, 0, 0, 0, c_mw, 0, 143);
        step(1, SW, 0, 0, 0, c_rst, 0, 144);
        step(1, SW, 0, 0, 1, c_rst, 0, 145);
        step(0, SW, 0, 0, 0, c_f0, 0, 146);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
